// File: rtl/scan_sel_gen.sv
// scan_sel_gen: masked channel-scan sequencer producing the 3-to-8 decoder select
module scan_sel_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         skip_mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [2:0] sel_n, first_idx, start_idx, nxt_idx;
    logic nxt_found, mode_q, mode_n;
    logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
    logic [7:0] mask_q, mask_n;
    // lowest unmasked channel for start/wrap, and lowest unmasked channel above sel
    always_comb begin
        first_idx = '0;
        start_idx = '0;
        nxt_idx = '0;
        nxt_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!mask_q[i]) first_idx = 3'(i);
            if (!skip_mask[i]) start_idx = 3'(i);
            if (!mask_q[i] && 3'(i) > sel) begin
                nxt_idx = 3'(i);
                nxt_found = 1'b1;
            end
        end
    end
    // next-state, channel advance and configuration capture
    always_comb begin
        state_n = state;
        sel_n = sel;
        cnt_n = cnt;
        mode_n = mode_q;
        dwell_n = dwell_q;
        mask_n = mask_q;
        case (state)
            IDLE: if (start && !stop && skip_mask != 8'hFF) begin
                state_n = SCAN;
                sel_n = start_idx;
                cnt_n = '0;
                mode_n = mode;
                dwell_n = dwell;
                mask_n = skip_mask;
            end
            SCAN: if (stop) state_n = IDLE;
                else if (en) begin
                    if (cnt == dwell_q) begin
                        cnt_n = '0;
                        if (nxt_found) sel_n = nxt_idx;
                        else if (mode_q) state_n = DONE;
                        else sel_n = first_idx;
                    end else cnt_n = cnt + 1'b1;
                end
            default: state_n = IDLE;
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            cnt <= '0;
            mode_q <= 1'b0;
            dwell_q <= '0;
            mask_q <= '0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            cnt <= cnt_n;
            mode_q <= mode_n;
            dwell_q <= dwell_n;
            mask_q <= mask_n;
        end
    end
    assign sel_valid = state == SCAN;
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule
